// File: rtl/usb_rx_pkt_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_pkt_ctrl_pkg
// Brief   : Shared types and constants for the USB full-speed RX packet
//           controller (packet classes, error codes, FSM encoding, PID fields).
// Revision: 1.0 - initial release
// ============================================================================
package usb_rx_pkt_ctrl_pkg;

    // Packet class reported alongside each status
    typedef enum logic [1:0] {
        PKT_NONE   = 2'd0,
        PKT_TOKEN  = 2'd1,
        PKT_DATA   = 2'd2,
        PKT_HSHAKE = 2'd3
    } pkt_t;

    // Reason for rejecting a packet; ERR_NONE while a packet is healthy
    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SYNC    = 3'd1,
        ERR_PID     = 3'd2,
        ERR_LEN     = 3'd3,
        ERR_CRC     = 3'd4,
        ERR_OVF     = 3'd5,
        ERR_TIMEOUT = 3'd6
    } err_t;

    // Controller state encoding
    typedef logic [3:0] state_t;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SYNC    = 4'd1;
    localparam logic [3:0] S_PID     = 4'd2;
    localparam logic [3:0] S_TOKEN   = 4'd3;
    localparam logic [3:0] S_DATA    = 4'd4;
    localparam logic [3:0] S_HSHAKE  = 4'd5;
    localparam logic [3:0] S_CHK_CRC = 4'd6;
    localparam logic [3:0] S_ERROR   = 4'd7;
    localparam logic [3:0] S_FLUSH   = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    // SYNC pattern as delivered by the byte shifter (LSB first on the wire)
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // PID[1:0] selects the packet class
    localparam logic [1:0] PID_TYPE_SPECIAL = 2'b00;
    localparam logic [1:0] PID_TYPE_TOKEN   = 2'b01;
    localparam logic [1:0] PID_TYPE_HSHAKE  = 2'b10;
    localparam logic [1:0] PID_TYPE_DATA    = 2'b11;

    // Upper PID nibble must be the bitwise complement of the lower one
    function automatic logic pid_valid(input logic [7:0] pid_byte);
        return pid_byte[3:0] == ~pid_byte[7:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_rx_pkt_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_pkt_ctrl_if
// Brief   : Bundle between the byte shifter / FIFO side (master) and the RX
//           packet controller (slave).
// Revision: 1.0 - initial release
// ============================================================================
interface usb_rx_pkt_ctrl_if #(
    parameter int CNT_W = 7
);
    import usb_rx_pkt_ctrl_pkg::*;

    // Shifter / CRC / FIFO side
    logic             d_edge;
    logic             byte_complete;
    logic [7:0]       rcv_byte;
    logic             eop;
    logic             crc5_ok;
    logic             crc16_ok;
    logic             fifo_full;

    // Controller side
    logic             enable_timer;
    logic             w_enable;
    logic [7:0]       rx_data;
    logic [3:0]       rx_pid;
    pkt_t             pkt_type;
    logic [CNT_W-1:0] payload_len;
    logic             rx_done;
    logic             rx_error;
    err_t             err_code;

    modport master (
        output d_edge, byte_complete, rcv_byte, eop, crc5_ok, crc16_ok, fifo_full,
        input  enable_timer, w_enable, rx_data, rx_pid, pkt_type, payload_len,
               rx_done, rx_error, err_code
    );

    modport slave (
        input  d_edge, byte_complete, rcv_byte, eop, crc5_ok, crc16_ok, fifo_full,
        output enable_timer, w_enable, rx_data, rx_pid, pkt_type, payload_len,
               rx_done, rx_error, err_code
    );

endinterface
`default_nettype wire

// File: rtl/usb_rx_pkt_ctrl_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_pkt_ctrl_timeout_cnt
// Brief   : Idle-gap counter. Counts enabled cycles since the last clear and
//           raises expired_o for one cycle when TIMEOUT cycles have elapsed.
// Revision: 1.0 - initial release
// ============================================================================
module usb_rx_pkt_ctrl_timeout_cnt #(
    parameter int TIMEOUT = 1024
) (
    input  wire logic clk,
    input  wire logic n_rst,
    input  wire logic clear_i,
    input  wire logic enable_i,
    output logic      expired_o
);
    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] C_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Expiry fires on the TIMEOUT-th quiet cycle; the count restarts afterwards
    always_comb begin
        expired_o = enable_i && !clear_i && (cnt_q == C_LAST);
        if (clear_i || !enable_i || expired_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : usb_rx_pkt_ctrl
// Brief   : USB full-speed receive packet controller. Checks SYNC and PID,
//           classifies the packet, enforces lengths, sequences the CRC check,
//           forwards data bytes to the RX FIFO and reports one status per
//           packet.
// Revision: 1.0 - initial release
// ============================================================================
module usb_rx_pkt_ctrl
    import usb_rx_pkt_ctrl_pkg::*;
#(
    parameter int MAX_PAYLOAD = 64,
    parameter int TIMEOUT     = 1024,
    parameter int CNT_W       = $clog2(MAX_PAYLOAD + 4)
) (
    input wire logic          clk,
    input wire logic          n_rst,
    usb_rx_pkt_ctrl_if.slave  rx
);
    // Largest legal DATA byte count: payload plus the two CRC16 bytes
    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_PAYLOAD + 2);
    localparam logic [CNT_W-1:0] C_TWO     = CNT_W'(2);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] payload_len_q, payload_len_d;
    logic [3:0]       pid_q, pid_d;
    pkt_t             pkt_type_q, pkt_type_d;
    err_t             err_q, err_d;
    logic             eop_seen_q, eop_seen_d;

    logic [CNT_W-1:0] cnt_new;
    logic             wr;
    logic             crc_ok;
    logic             tmo_en;
    logic             tmo_clr;
    logic             tmo_expired;

    // Quiet-line watchdog: any byte or eop restarts it
    assign tmo_en  = (state_q == S_SYNC)  || (state_q == S_PID)    ||
                     (state_q == S_TOKEN) || (state_q == S_DATA)   ||
                     (state_q == S_HSHAKE)|| (state_q == S_FLUSH);
    assign tmo_clr = rx.byte_complete || rx.eop;

    usb_rx_pkt_ctrl_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear_i   (tmo_clr),
        .enable_i  (tmo_en),
        .expired_o (tmo_expired)
    );

    // Next-state logic; a byte arriving with eop is accounted before the eop rule
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        payload_len_d = payload_len_q;
        pid_d         = pid_q;
        pkt_type_d    = pkt_type_q;
        err_d         = err_q;
        eop_seen_d    = eop_seen_q || rx.eop;
        wr            = 1'b0;
        cnt_new       = count_q + CNT_W'(rx.byte_complete);
        crc_ok        = (pkt_type_q == PKT_TOKEN) ? rx.crc5_ok : rx.crc16_ok;

        case (state_q)
            S_IDLE: begin
                eop_seen_d = 1'b0;
                if (rx.d_edge) begin
                    state_d       = S_SYNC;
                    err_d         = ERR_NONE;
                    count_d       = '0;
                    payload_len_d = '0;
                end
            end

            S_SYNC: begin
                if (rx.byte_complete && (rx.rcv_byte != SYNC_BYTE)) begin
                    state_d = S_ERROR;
                    err_d   = ERR_SYNC;
                end else if (rx.eop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LEN;
                end else if (rx.byte_complete) begin
                    state_d = S_PID;
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            S_PID: begin
                if (rx.byte_complete) begin
                    if (!pid_valid(rx.rcv_byte) || (rx.rcv_byte[1:0] == PID_TYPE_SPECIAL)) begin
                        state_d = S_ERROR;
                        err_d   = ERR_PID;
                    end else begin
                        pid_d = rx.rcv_byte[3:0];
                        case (rx.rcv_byte[1:0])
                            PID_TYPE_TOKEN: begin
                                pkt_type_d = PKT_TOKEN;
                                state_d    = S_TOKEN;
                            end
                            PID_TYPE_DATA: begin
                                pkt_type_d = PKT_DATA;
                                state_d    = S_DATA;
                            end
                            default: begin
                                pkt_type_d = PKT_HSHAKE;
                                state_d    = S_HSHAKE;
                            end
                        endcase
                        // Only a handshake may legally end right after its PID
                        if (rx.eop) begin
                            if (rx.rcv_byte[1:0] == PID_TYPE_HSHAKE) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_ERROR;
                                err_d   = ERR_LEN;
                            end
                        end
                    end
                end else if (rx.eop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LEN;
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            S_TOKEN: begin
                count_d = cnt_new;
                if (rx.byte_complete && (cnt_new > C_TWO)) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LEN;
                end else if (rx.eop) begin
                    if (cnt_new == C_TWO) begin
                        state_d = S_CHK_CRC;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = ERR_LEN;
                    end
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            S_DATA: begin
                // The overflowing byte itself is never written to the FIFO
                if (rx.byte_complete && (rx.fifo_full || (cnt_new > C_MAX_CNT))) begin
                    state_d = S_ERROR;
                    err_d   = ERR_OVF;
                end else begin
                    count_d = cnt_new;
                    wr      = rx.byte_complete;
                    if (rx.eop) begin
                        if (cnt_new < C_TWO) begin
                            state_d = S_ERROR;
                            err_d   = ERR_LEN;
                        end else begin
                            state_d = S_CHK_CRC;
                        end
                    end else if (tmo_expired) begin
                        state_d = S_ERROR;
                        err_d   = ERR_TIMEOUT;
                    end
                end
            end

            S_HSHAKE: begin
                if (rx.byte_complete) begin
                    state_d = S_ERROR;
                    err_d   = ERR_LEN;
                end else if (rx.eop) begin
                    state_d = S_DONE;
                end else if (tmo_expired) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TIMEOUT;
                end
            end

            S_CHK_CRC: begin
                if (crc_ok) begin
                    state_d = S_DONE;
                    if (pkt_type_q == PKT_DATA) begin
                        payload_len_d = count_q - C_TWO;
                    end
                end else begin
                    state_d = S_ERROR;
                    err_d   = ERR_CRC;
                end
            end

            // Packet already terminated -> pass silently through DONE
            S_ERROR: begin
                state_d = (eop_seen_q || rx.eop) ? S_DONE : S_FLUSH;
            end

            S_FLUSH: begin
                if (rx.eop || tmo_expired) begin
                    state_d = S_IDLE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and packet-context registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            payload_len_q <= '0;
            pid_q         <= '0;
            pkt_type_q    <= PKT_NONE;
            err_q         <= ERR_NONE;
            eop_seen_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            payload_len_q <= payload_len_d;
            pid_q         <= pid_d;
            pkt_type_q    <= pkt_type_d;
            err_q         <= err_d;
            eop_seen_q    <= eop_seen_d;
        end
    end

    // Outputs; rx_done is suppressed when DONE is reached through ERROR
    always_comb begin
        rx.enable_timer = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
        rx.w_enable     = wr;
        rx.rx_data      = wr ? rx.rcv_byte : 8'h00;
        rx.rx_pid       = pid_q;
        rx.pkt_type     = pkt_type_q;
        rx.payload_len  = payload_len_q;
        rx.rx_done      = (state_q == S_DONE) && (err_q == ERR_NONE);
        rx.rx_error     = (state_q == S_ERROR);
        rx.err_code     = err_q;
    end

endmodule
`default_nettype wire
